// File: rtl/imem_loader.sv
// Framed byte-stream loader that writes a program image into instruction memory and holds the CPU until done.
// Optional `IMEM_LOADER_CHKSUM_EN adds a trailing 8-bit additive checksum byte to every frame.
module imem_loader #(
  parameter int ADDR_W   = 64,
  parameter int LEN_W    = 16,
  parameter int MEM_SIZE = 1024
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              in_valid_i,
  input  logic [7:0]        in_data_i,
  output logic              in_ready_o,
  input  logic              reload_i,
  output logic              mem_wen_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [7:0]        mem_wdata_o,
  output logic              cpu_hold_o,
  output logic              done_o,
  output logic              err_o
);

  localparam int ADDR_BYTES = ADDR_W / 8;
  localparam int LEN_BYTES  = LEN_W / 8;
  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_LEN, S_DATA, S_CHK, S_DONE, S_ERR
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;
  logic                err_q, err_d;
  logic                wen_q, wen_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          wdata_q, wdata_d;
  logic                done_q, done_d;
`ifdef IMEM_LOADER_CHKSUM_EN
  logic [7:0]          sum_q, sum_d;
`endif

  logic              consume;
  logic [ADDR_W-1:0] wr_addr;
  logic              in_range;

  assign consume  = in_valid_i && in_ready_o;
  assign wr_addr  = base_q + ADDR_W'(cnt_q);
  assign in_range = wr_addr < ADDR_W'(MEM_SIZE);

  assign in_ready_o  = !(state_q inside {S_DONE, S_ERR});
  assign cpu_hold_o  = (state_q != S_DONE);
  assign mem_wen_o   = wen_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign done_o      = done_q;
  assign err_o       = err_q;

  // NOTE: every variable gets its default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    wen_d   = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
`ifdef IMEM_LOADER_CHKSUM_EN
    sum_d   = sum_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (consume && in_data_i == SYNC_BYTE) begin
          state_d = S_ADDR;
          cnt_d   = '0;
        end
      end

      S_ADDR: begin
        if (consume) begin
          // Little-endian fields shift in from the top so the first byte lands at bit 0.
          base_d = (base_q >> 8) | (ADDR_W'(in_data_i) << (ADDR_W - 8));
          if (cnt_q == LEN_W'(ADDR_BYTES - 1)) begin
            cnt_d   = '0;
            state_d = S_LEN;
          end else begin
            cnt_d = cnt_q + LEN_W'(1);
          end
        end
      end

      S_LEN: begin
        if (consume) begin
          len_d = (len_q >> 8) | (LEN_W'(in_data_i) << (LEN_W - 8));
          if (cnt_q == LEN_W'(LEN_BYTES - 1)) begin
            cnt_d = '0;
            if (len_d == '0) begin
`ifdef IMEM_LOADER_CHKSUM_EN
              state_d = S_CHK;
`else
              state_d = S_DONE;
`endif
            end else begin
              state_d = S_DATA;
            end
          end else begin
            cnt_d = cnt_q + LEN_W'(1);
          end
        end
      end

      S_DATA: begin
        if (consume) begin
          addr_d  = wr_addr;
          wdata_d = in_data_i;
          if (in_range) wen_d = 1'b1;
          else          err_d = 1'b1;
`ifdef IMEM_LOADER_CHKSUM_EN
          sum_d = sum_q + in_data_i;
`endif
          if (cnt_q == len_q - LEN_W'(1)) begin
            cnt_d = '0;
`ifdef IMEM_LOADER_CHKSUM_EN
            state_d = S_CHK;
`else
            state_d = err_d ? S_ERR : S_DONE;
`endif
          end else begin
            cnt_d = cnt_q + LEN_W'(1);
          end
        end
      end

`ifdef IMEM_LOADER_CHKSUM_EN
      S_CHK: begin
        if (consume) begin
          if (in_data_i == sum_q && !err_q) begin
            state_d = S_DONE;
          end else begin
            err_d   = 1'b1;
            state_d = S_ERR;
          end
        end
      end
`endif

      S_DONE, S_ERR: begin
        if (reload_i) begin
          state_d = S_IDLE;
          err_d   = 1'b0;
          cnt_d   = '0;
          base_d  = '0;
          len_d   = '0;
`ifdef IMEM_LOADER_CHKSUM_EN
          sum_d   = '0;
`endif
        end
      end

      default: state_d = S_IDLE;
    endcase

    done_d = (state_d == S_DONE) && (state_q != S_DONE);
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      wen_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
`ifdef IMEM_LOADER_CHKSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      wen_q   <= wen_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
`ifdef IMEM_LOADER_CHKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table-driven frames, corner-case sequences and random frames
// checked against a frame-level model of expected writes, done and err.
module tb_imem_loader;

  localparam int AW = 64;
  localparam int LW = 16;
  localparam int MS = 1024;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = '0;
  logic          in_ready;
  logic          reload = 1'b0;
  logic          mem_wen;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic          cpu_hold;
  logic          done;
  logic          err;

  imem_loader #(.ADDR_W(AW), .LEN_W(LW), .MEM_SIZE(MS)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .in_valid_i (in_valid),
    .in_data_i  (in_data),
    .in_ready_o (in_ready),
    .reload_i   (reload),
    .mem_wen_o  (mem_wen),
    .mem_addr_o (mem_addr),
    .mem_wdata_o(mem_wdata),
    .cpu_hold_o (cpu_hold),
    .done_o     (done),
    .err_o      (err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;
  logic [AW+7:0] got_q [$];
  logic [AW+7:0] exp_q [$];
  logic [7:0]    pl [$];
  logic          cons_q = 1'b0;

  task automatic check(input string name, input logic [AW+7:0] act, input logic [AW+7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cons_q <= in_valid && in_ready;

  // Every write must follow a byte consumed on the immediately preceding edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_wen) begin
        got_q.push_back({mem_addr, mem_wdata});
        check("wen_latency", AW'(cons_q), AW'(1));
      end
      if (done) begin
        done_cnt++;
        check("hold_at_done", AW'(cpu_hold), AW'(0));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    in_valid = 1'b1;
    in_data  = b;
    t = 0;
    while (!in_ready && t < 20) begin
      tick();
      t++;
    end
    if (!in_ready) check("send_timeout", AW'(in_ready), AW'(1));
    tick();
    if (gap > 0) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      repeat (gap) tick();
    end
  endtask

  task automatic send_header(input logic [AW-1:0] base, input int len, input int gap);
    logic [LW-1:0] l;
    l = LW'(len);
    send_byte(8'hA5, gap);
    for (int j = 0; j < AW / 8; j++) send_byte(base[8*j +: 8], gap);
    for (int j = 0; j < LW / 8; j++) send_byte(l[8*j +: 8], gap);
  endtask

  // exp_err / exp_writes of -1 mean "take the model's answer".
  task automatic run_frame(input string tag, input logic [AW-1:0] base, input int gap, input int junk,
                           input bit bad_chk, input int exp_err, input int exp_writes);
    logic [7:0]    sum;
    logic [AW-1:0] a;
    bit            m_err;
    int            done0;
    int            t;
    got_q.delete();
    exp_q.delete();
    sum   = '0;
    m_err = 1'b0;
    done0 = done_cnt;
    for (int k = 0; k < pl.size(); k++) begin
      a   = base + AW'(k);
      sum = sum + pl[k];
      if (a < AW'(MS)) exp_q.push_back({a, pl[k]});
      else             m_err = 1'b1;
    end
`ifdef IMEM_LOADER_CHKSUM_EN
    if (bad_chk) m_err = 1'b1;
`endif
    if (exp_err < 0) exp_err = int'(m_err);
    if (exp_writes < 0) exp_writes = exp_q.size();

    for (int j = 0; j < junk; j++) send_byte((j == 0) ? 8'h00 : 8'h7F, gap);
    send_header(base, pl.size(), gap);
    for (int k = 0; k < pl.size(); k++) send_byte(pl[k], gap);
`ifdef IMEM_LOADER_CHKSUM_EN
    send_byte(bad_chk ? sum + 8'd1 : sum, gap);
`endif
    in_valid = 1'b0;
    t = 0;
    while (in_ready && t < 20) begin
      tick();
      t++;
    end
    if (in_ready) check({tag, "_end_timeout"}, AW'(in_ready), AW'(0));
    repeat (2) tick();

    check({tag, "_err"}, AW'(err), AW'(exp_err));
    check({tag, "_ready"}, AW'(in_ready), AW'(0));
    check({tag, "_hold"}, AW'(cpu_hold), AW'(exp_err));
    check({tag, "_done_cnt"}, AW'(done_cnt - done0), AW'(exp_err == 0));
    check({tag, "_nwrites"}, AW'(got_q.size()), AW'(exp_writes));
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
      check({tag, "_write"}, got_q[k], exp_q[k]);

    reload = 1'b1;
    tick();
    reload = 1'b0;
    check({tag, "_rl_err"}, AW'(err), AW'(0));
    check({tag, "_rl_ready"}, AW'(in_ready), AW'(1));
    check({tag, "_rl_hold"}, AW'(cpu_hold), AW'(1));
  endtask

  task automatic fill_payload(input int len, input bit has_fixed, input logic [31:0] fixed);
    pl.delete();
    for (int k = 0; k < len; k++)
      pl.push_back((has_fixed && k < 4) ? fixed[8*k +: 8] : 8'($urandom));
  endtask

  typedef struct {
    string         name;
    logic [AW-1:0] base;
    int            len;
    bit            has_fixed;
    logic [31:0]   fixed;
    int            gap;
    int            junk;
    int            exp_err;
    int            exp_writes;
  } vec_t;

  vec_t vecs [8];

  initial begin
    vecs[0] = '{"basic",     64'h0,                 3,   1'b1, 32'h000A_F230, 0, 0, 0, 3};
    vecs[1] = '{"toggle",    64'h0,                 3,   1'b1, 32'h000A_F230, 1, 0, 0, 3};
    vecs[2] = '{"overrun",   64'h3FE,               4,   1'b1, 32'h4433_2211, 0, 0, 1, 2};
    vecs[3] = '{"junk_len0", 64'h10,                0,   1'b0, 32'h0,         0, 2, 0, 0};
    vecs[4] = '{"last_byte", 64'h3FF,               1,   1'b0, 32'h0,         0, 0, 0, 1};
    vecs[5] = '{"at_size",   64'h400,               2,   1'b0, 32'h0,         2, 0, 1, 0};
    vecs[6] = '{"wrap",      64'hFFFF_FFFF_FFFF_FFFE, 4, 1'b0, 32'h0,         0, 0, 1, 2};
    vecs[7] = '{"long",      64'h100,               300, 1'b0, 32'h0,         0, 0, 0, 300};

    #1 rst_n = 1'b0;
    #2;
    check("rst_ready", AW'(in_ready), AW'(1));
    check("rst_hold",  AW'(cpu_hold), AW'(1));
    check("rst_wen",   AW'(mem_wen), AW'(0));
    check("rst_addr",  AW'(mem_addr), AW'(0));
    check("rst_wdata", AW'(mem_wdata), AW'(0));
    check("rst_done",  AW'(done), AW'(0));
    check("rst_err",   AW'(err), AW'(0));
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    foreach (vecs[i]) begin
      fill_payload(vecs[i].len, vecs[i].has_fixed, vecs[i].fixed);
      run_frame(vecs[i].name, vecs[i].base, vecs[i].gap, vecs[i].junk, 1'b0,
                vecs[i].exp_err, vecs[i].exp_writes);
    end

`ifdef IMEM_LOADER_CHKSUM_EN
    fill_payload(2, 1'b1, 32'h0000_0201);
    run_frame("chk_bad", 64'h0, 0, 0, 1'b1, 1, 2);
    run_frame("chk_good", 64'h0, 0, 0, 1'b0, 0, 2);
`endif

    // Reset in the middle of a payload: already-issued writes stand, the rest is discarded.
    got_q.delete();
    fill_payload(5, 1'b0, 32'h0);
    send_header(64'h20, 5, 0);
    send_byte(pl[0], 0);
    send_byte(pl[1], 0);
    in_valid = 1'b0;
    repeat (2) tick();
    check("midrst_nwrites", AW'(got_q.size()), AW'(2));
    if (got_q.size() > 0) check("midrst_w0", got_q[0], {64'h20, pl[0]});
    #2 rst_n = 1'b0;
    #1;
    check("midrst_ready", AW'(in_ready), AW'(1));
    check("midrst_hold",  AW'(cpu_hold), AW'(1));
    check("midrst_wen",   AW'(mem_wen), AW'(0));
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    fill_payload(3, 1'b0, 32'h0);
    run_frame("after_rst", 64'h40, 0, 0, 1'b0, 0, 3);

    for (int r = 0; r < 20; r++) begin
      logic [AW-1:0] base;
      case ($urandom_range(0, 2))
        0:       base = AW'($urandom_range(0, MS - 20));
        1:       base = AW'(MS - 16 + $urandom_range(0, 20));
        default: base = {32'($urandom), 32'($urandom)};
      endcase
      fill_payload($urandom_range(0, 12), 1'b0, 32'h0);
      run_frame("rand", base, $urandom_range(0, 2), $urandom_range(0, 1),
                1'($urandom_range(0, 1)), -1, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
